// File: rtl/io_output_ctrl.sv
// Memory-mapped output peripheral: LEDR/LEDG/HEX registers with byte-lane writes and a
// FIFO-queued HD44780-style LCD port. Optional macro IO_HEX_DECODE_EN enables nibble-to-7-segment decode.
module io_output_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int N_HEX     = 8,
  parameter int LEDR_W    = 32,
  parameter int LEDG_W    = 32,
  parameter int LCD_DEPTH = 4,
  parameter int LCD_SETUP = 2,
  parameter int LCD_PULSE = 4,
  parameter int LCD_HOLD  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [31:0]          i_wr_data,
  input  logic                 i_wr_en,
  input  logic [3:0]           i_bmask,
  output logic [31:0]          o_ld_data,
  output logic [31:0]          o_io_ledr,
  output logic [31:0]          o_io_ledg,
  output logic [7*N_HEX-1:0]   o_io_hex,
  output logic [31:0]          o_io_lcd,
  output logic                 o_lcd_busy
);

  localparam int PW   = $clog2(LCD_DEPTH);
  localparam int CW   = PW + 1;
  localparam int TMAX = (LCD_SETUP > LCD_PULSE) ?
                        ((LCD_SETUP > LCD_HOLD) ? LCD_SETUP : LCD_HOLD) :
                        ((LCD_PULSE > LCD_HOLD) ? LCD_PULSE : LCD_HOLD);
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [31:0] LEDR_MSK = 32'((64'd1 << LEDR_W) - 64'd1);
  localparam logic [31:0] LEDG_MSK = 32'((64'd1 << LEDG_W) - 64'd1);
  localparam logic [ADDR_W-1:0] A_LEDR = ADDR_W'(32'h7000);
  localparam logic [ADDR_W-1:0] A_LEDG = ADDR_W'(32'h7010);
  localparam logic [ADDR_W-1:0] A_HEX  = ADDR_W'(32'h7020);
  localparam logic [ADDR_W-1:0] A_LCDD = ADDR_W'(32'h7030);
  localparam logic [ADDR_W-1:0] A_LCDC = ADDR_W'(32'h7034);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_PULSE, ST_HOLD} lcd_state_e;

  lcd_state_e        state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [31:0]       ledr_q, ledr_d, ledg_q, ledg_d;
  logic              on_q, on_d, ovf_q, ovf_d;
  logic [8:0]        lcd_q, lcd_d, last_q, last_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [8:0]        fifo_mem [LCD_DEPTH];
  logic [8*N_HEX-1:0] hex_rd;

  logic sel_ledr, sel_ledg, sel_hex, sel_lcdd, sel_lcdc;
  logic push_req, push_ok, pop, full;

  assign sel_ledr = (i_addr == A_LEDR);
  assign sel_ledg = (i_addr == A_LEDG);
  assign sel_lcdd = (i_addr == A_LCDD);
  assign sel_lcdc = (i_addr == A_LCDC);
  assign sel_hex  = (i_addr[ADDR_W-1:4] == A_HEX[ADDR_W-1:4]) &&
                    (32'(i_addr[3:0]) < 32'(N_HEX));

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign full     = (count_q == CW'(LCD_DEPTH));
  assign pop      = (state_q == ST_IDLE) && (count_q != '0);
  assign push_req = i_wr_en && sel_lcdd && i_bmask[0];
  assign push_ok  = push_req && (!full || pop);

`ifdef IO_HEX_DECODE_EN
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return ~s;
  endfunction
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_HEX; gi++) begin : g_hex
      logic [7:0] dig_q, dig_d;
      always_comb begin
        dig_d = dig_q;
        if (i_wr_en && sel_hex && i_bmask[0] && (i_addr[3:0] == 4'(gi))) begin
`ifdef IO_HEX_DECODE_EN
          dig_d = {i_wr_data[7], 3'b000, i_wr_data[3:0]};
`else
          dig_d = {1'b0, i_wr_data[6:0]};
`endif
        end
      end
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) dig_q <= '0;
        else          dig_q <= dig_d;
      end
      assign hex_rd[8*gi +: 8] = dig_q;
`ifdef IO_HEX_DECODE_EN
      assign o_io_hex[7*gi +: 7] = dig_q[7] ? 7'h7F : seg7(dig_q[3:0]);
`else
      assign o_io_hex[7*gi +: 7] = dig_q[6:0];
`endif
    end
  endgenerate

  always_comb begin
    ledr_d   = ledr_q;
    ledg_d   = ledg_q;
    on_d     = on_q;
    ovf_d    = ovf_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int k = 0; k < 4; k++) begin
      if (i_wr_en && i_bmask[k] && sel_ledr) ledr_d[8*k +: 8] = i_wr_data[8*k +: 8];
      if (i_wr_en && i_bmask[k] && sel_ledg) ledg_d[8*k +: 8] = i_wr_data[8*k +: 8];
    end
    ledr_d = ledr_d & LEDR_MSK;
    ledg_d = ledg_d & LEDG_MSK;
    if (i_wr_en && sel_lcdc && i_bmask[0]) begin
      on_d = i_wr_data[0];
      if (i_wr_data[3]) ovf_d = 1'b0;
    end
    if (push_req && !push_ok) ovf_d = 1'b1;
    if (push_ok) begin
      last_d   = {i_wr_data[10], i_wr_data[7:0]};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push_ok) - CW'(pop);
  end

  // LCD timing FSM; the timer restarts at every phase entry.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    lcd_d   = lcd_q;
    case (state_q)
      ST_IDLE: if (pop) begin
        lcd_d   = fifo_mem[rd_ptr_q];
        state_d = ST_SETUP;
        tmr_d   = '0;
      end
      ST_SETUP: if (tmr_q == TW'(LCD_SETUP - 1)) begin
        state_d = ST_PULSE;
        tmr_d   = '0;
      end else tmr_d = tmr_q + 1'b1;
      ST_PULSE: if (tmr_q == TW'(LCD_PULSE - 1)) begin
        state_d = ST_HOLD;
        tmr_d   = '0;
      end else tmr_d = tmr_q + 1'b1;
      ST_HOLD: if (tmr_q == TW'(LCD_HOLD - 1)) begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end else tmr_d = tmr_q + 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= {i_wr_data[10], i_wr_data[7:0]};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      tmr_q    <= '0;
      ledr_q   <= '0;
      ledg_q   <= '0;
      on_q     <= 1'b0;
      ovf_q    <= 1'b0;
      lcd_q    <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      ledr_q   <= ledr_d;
      ledg_q   <= ledg_d;
      on_q     <= on_d;
      ovf_q    <= ovf_d;
      lcd_q    <= lcd_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_lcd_busy = (state_q != ST_IDLE) || (count_q != '0);
  assign o_io_ledr  = ledr_q;
  assign o_io_ledg  = ledg_q;
  assign o_io_lcd   = {on_q, 20'b0, lcd_q[8], 1'b0, (state_q == ST_PULSE), lcd_q[7:0]};

  always_comb begin
    o_ld_data = '0;
    if (sel_ledr)      o_ld_data = ledr_q;
    else if (sel_ledg) o_ld_data = ledg_q;
    else if (sel_lcdd) o_ld_data = {21'b0, last_q[8], 2'b00, last_q[7:0]};
    else if (sel_lcdc) o_ld_data = {19'b0, 5'(count_q), 4'b0, ovf_q, full, o_lcd_busy, on_q};
    else if (sel_hex) begin
      for (int i = 0; i < N_HEX; i++) begin
        if (i_addr[3:0] == 4'(i)) o_ld_data = {24'b0, hex_rd[8*i +: 8]};
      end
    end
  end

endmodule

// File: tb/tb_io_output_ctrl.sv
// Self-checking bench for io_output_ctrl: register writes/loads, HEX, and LCD FIFO/timing via a scoreboard.
module tb_io_output_ctrl;
  localparam int N_HEX = 8;
  localparam int S = 2, P = 4, H = 2;
  localparam int PERIOD = S + P + H + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] i_addr = '0;
  logic [31:0] i_wr_data = '0;
  logic        i_wr_en = 1'b0;
  logic [3:0]  i_bmask = '0;
  logic [31:0] o_ld_data, o_io_ledr, o_io_ledg, o_io_lcd;
  logic [7*N_HEX-1:0] o_io_hex;
  logic        o_lcd_busy;

  io_output_ctrl #(.ADDR_W(16), .N_HEX(N_HEX), .LEDR_W(32), .LEDG_W(32), .LCD_DEPTH(4),
                   .LCD_SETUP(S), .LCD_PULSE(P), .LCD_HOLD(H)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_addr(i_addr), .i_wr_data(i_wr_data),
    .i_wr_en(i_wr_en), .i_bmask(i_bmask), .o_ld_data(o_ld_data), .o_io_ledr(o_io_ledr),
    .o_io_ledg(o_io_ledg), .o_io_hex(o_io_hex), .o_io_lcd(o_io_lcd), .o_lcd_busy(o_lcd_busy));

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  logic [8:0] sb[$];
  int rise_t[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else $display("ok   %s: 0x%0h", tag, got);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
    i_addr = a; i_wr_data = d; i_bmask = m; i_wr_en = 1'b1;
    @(posedge clk); #1;
    i_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    i_addr = a; #1; d = o_ld_data;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_lcd_busy && n < 300) begin step(); n++; end
    check_val("idle_reached", o_lcd_busy, 0);
  endtask

  initial forever begin
    @(posedge clk); cyc++;
  end

  // EN monitor: each rising edge pops the scoreboard; each pulse width is checked.
  initial begin
    logic en, en_prev;
    int width;
    logic [8:0] exp;
    en_prev = 1'b0; width = 0;
    forever begin
      @(negedge clk);
      en = o_io_lcd[8];
      if (!rst_n) begin
        en_prev = 1'b0; width = 0;
      end else begin
        if (en && !en_prev) begin
          rise_t.push_back(cyc);
          check_val("lcd_pending", (sb.size() > 0), 1);
          if (sb.size() > 0) begin
            exp = sb.pop_front();
            check_val("lcd_word", {o_io_lcd[10], o_io_lcd[7:0]}, exp);
          end
          width = 1;
        end else if (en) width++;
        else if (en_prev) check_val("en_width", width, P);
        en_prev = en;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] w [6];
    logic [63:0] hex_exp;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ledr", o_io_ledr, 0);
    check_val("rst_ledg", o_io_ledg, 0);
    check_val("rst_hex", 64'(o_io_hex), 0);
    check_val("rst_lcd", o_io_lcd, 0);
    check_val("rst_busy", o_lcd_busy, 0);
    rst_n = 1'b1;
    step();
    rd(16'h7034, d); check_val("rst_status", d, 0);

    // LED byte-lane writes
    wr(16'h7000, 32'hDEADBEEF, 4'b0101);
    check_val("ledr_out", o_io_ledr, 32'h00AD00EF);
    rd(16'h7000, d); check_val("ledr_rd", d, 32'h00AD00EF);
    rd(16'h7050, d); check_val("unmapped_rd", d, 0);
    wr(16'h7010, 32'h12345678, 4'b1111);
    wr(16'h7010, 32'hFF000000, 4'b1000);
    check_val("ledg_out", o_io_ledg, 32'hFF345678);
    wr(16'h7050, 32'hFFFFFFFF, 4'b1111);
    check_val("unmapped_wr", o_io_ledr, 32'h00AD00EF);

    // HEX digit 3
    wr(16'h7023, 32'h7F, 4'b0001);
`ifdef IO_HEX_DECODE_EN
    hex_exp = 64'(7'h0E) << 21;
    check_val("hex_F", 64'(o_io_hex), hex_exp);
    rd(16'h7023, d); check_val("hex_rd_F", d, 32'h0F);
    wr(16'h7023, 32'h3, 4'b0001);
    check_val("hex_3", 64'(o_io_hex), 64'(7'h30) << 21);
    wr(16'h7023, 32'h80, 4'b0001);
    check_val("hex_blank", 64'(o_io_hex), 64'(7'h7F) << 21);
    rd(16'h7023, d); check_val("hex_rd_blank", d, 32'h80);
`else
    hex_exp = 64'(7'h7F) << 21;
    check_val("hex_raw", 64'(o_io_hex), hex_exp);
    rd(16'h7023, d); check_val("hex_rd_raw", d, 32'h7F);
    wr(16'h7022, 32'h15, 4'b0000);
    check_val("hex_nomask", 64'(o_io_hex), hex_exp);
`endif

    // Single LCD word: timing of EN and busy relative to the push edge
    wr(16'h7034, 32'h1, 4'b0001);
    sb.push_back(9'h141);
    wr(16'h7030, 32'h441, 4'b0001);
    check_val("lcd_busy_k0", o_lcd_busy, 1);
    for (int k = 1; k <= 10; k++) begin
      step();
      check_val($sformatf("lcd_en_k%0d", k), o_io_lcd[8], (k >= 1 + S && k < 1 + S + P));
      check_val($sformatf("lcd_busy_k%0d", k), o_lcd_busy, (k < 1 + S + P + H));
      if (k == 1) check_val("lcd_word_k1", o_io_lcd, 32'h80000441);
    end
    wait_idle();

    // Six back-to-back pushes: 5 accepted, 6th overflows
    for (int i = 0; i < 6; i++) w[i] = (32'(i % 2) << 10) | (32'h30 + 32'(i));
    rise_t.delete();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) sb.push_back({w[i][10], w[i][7:0]});
      wr(16'h7030, w[i], 4'b0001);
    end
    rd(16'h7034, d); check_val("ovf_status", d, 32'h0000040F);
    rd(16'h7030, d); check_val("last_word", d, 32'h00000034);
    wait_idle();
    repeat (2) step();
    check_val("burst_pulses", rise_t.size(), 5);
    for (int i = 1; i < rise_t.size(); i++)
      check_val($sformatf("burst_gap%0d", i), rise_t[i] - rise_t[i-1], PERIOD);
    wr(16'h7034, 32'h8, 4'b0001);
    rd(16'h7034, d); check_val("ovf_clear", d, 0);

    // Push into a full FIFO on the exact edge the FSM pops
    rise_t.delete();
    for (int i = 0; i < 5; i++) begin
      sb.push_back({w[i][10], w[i][7:0]});
      wr(16'h7030, w[i], 4'b0001);
    end
    rd(16'h7034, d); check_val("full_status", d, 32'h00000406);
    repeat (S + P + H - 3) step();
    check_val("pre_pop_en", o_io_lcd[8], 0);
    sb.push_back({w[5][10], w[5][7:0]});
    wr(16'h7030, w[5], 4'b0001);
    rd(16'h7034, d); check_val("pop_push_status", d, 32'h00000406);
    wait_idle();
    repeat (2) step();
    check_val("pop_push_pulses", rise_t.size(), 6);

    // Reset during PULSE with 3 entries queued
    rise_t.delete();
    for (int i = 0; i < 4; i++) begin
      sb.push_back({w[i][10], w[i][7:0]});
      wr(16'h7030, w[i], 4'b0001);
    end
    check_val("pulse_before_rst", o_io_lcd[8], 1);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_lcd", o_io_lcd, 0);
    check_val("rst_mid_busy", o_lcd_busy, 0);
    check_val("rst_mid_ledr", o_io_ledr, 0);
    sb.delete();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (40) step();
    check_val("post_rst_busy", o_lcd_busy, 0);
    check_val("post_rst_pulses", rise_t.size(), 1);
    rd(16'h7034, d); check_val("post_rst_status", d, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
